// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing the memory map between fetch and load/store ports
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   if_req_*  / if_resp_*        instruction-fetch request (valid/ready) and 1-cycle response
//   d_req_*   / d_resp_*         load/store request (valid/ready) and 1-cycle response
//   mem_address/write_data/
//   write_enable, mem_read_data  single-port memory map (combinational read)
//   conflict_count               saturating count of cycles with both requesters valid
module mem_port_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [31:0]      if_req_addr,
    output logic             if_resp_valid,
    output logic [31:0]      if_resp_data,
    output logic             if_resp_err,
    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [31:0]      d_req_addr,
    input  logic [31:0]      d_req_wdata,
    input  logic [3:0]       d_req_be,
    output logic             d_resp_valid,
    output logic [31:0]      d_resp_data,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    output logic [3:0]       mem_write_enable,
    input  logic [31:0]      mem_read_data,
    output logic [CNT_W-1:0] conflict_count
);

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_RESP_IF = 2'd1;
    localparam logic [1:0] ST_RESP_D  = 2'd2;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       last_grant;
    logic [1:0] state;
    logic       grant_if;
    logic       grant_d;
    logic       if_misaligned;
    logic       conflict;

    // Grants are qualified by reset_n so nothing reaches the memory map while in reset.
    always_comb begin
        conflict      = if_req_valid && d_req_valid;
        grant_d       = reset_n && d_req_valid && (!if_req_valid || (last_grant == GRANT_IF));
        grant_if      = reset_n && if_req_valid && !grant_d;
        if_misaligned = (if_req_addr[1:0] != 2'b00);
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    always_comb begin
        mem_address      = 32'h0;
        mem_write_data   = 32'h0;
        mem_write_enable = 4'h0;
        if (grant_d) begin
            mem_address      = d_req_addr;
            mem_write_data   = d_req_wdata;
            mem_write_enable = d_req_be;
        end else if (grant_if) begin
            // A misaligned fetch still burns the slot but must not touch the memory map.
            mem_address = if_misaligned ? 32'h0 : if_req_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_NONE;
            last_grant     <= GRANT_IF;
            conflict_count <= '0;
            if_resp_data   <= 32'h0;
            if_resp_err    <= 1'b0;
            d_resp_data    <= 32'h0;
        end else begin
            if (grant_if) begin
                state      <= ST_RESP_IF;
                last_grant <= GRANT_IF;
            end else if (grant_d) begin
                state      <= ST_RESP_D;
                last_grant <= GRANT_D;
            end else begin
                state <= ST_NONE;
            end

            if (conflict && (conflict_count != CNT_MAX)) begin
                conflict_count <= conflict_count + CNT_ONE;
            end

            if_resp_data <= (grant_if && !if_misaligned) ? mem_read_data : 32'h0;
            if_resp_err  <= grant_if && if_misaligned;
            // Stores return zero rather than whatever the map happens to read back.
            d_resp_data  <= (grant_d && (d_req_be == 4'h0)) ? mem_read_data : 32'h0;
        end
    end

    assign if_resp_valid = (state == ST_RESP_IF);
    assign d_resp_valid  = (state == ST_RESP_D);

endmodule
